// File: rtl/gpio_output_stage.sv
// Purpose: single-GPIO output driver executing SET/CLEAR/TOGGLE/PULSE commands and mapping level onto pad out/oe.
// Latency: level and pad outputs update on the accepting edge; done_o strobes for the cycle after the completing edge.
// Backpressure: cmd_ready_o is low while disabled or while a PULSE runs; a held valid waits for IDLE.
module gpio_output_stage #(
    parameter int unsigned CntWidth   = 16,
    parameter logic        ResetLevel = 1'b0
) (
    input  logic                clk,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic [1:0]          mode_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [1:0]          cmd_op_i,
    input  logic [CntWidth-1:0] cmd_len_i,
    output logic                gpio_out_o,
    output logic                gpio_oe_o,
    output logic                level_o,
    output logic                busy_o,
    output logic                done_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_e;

    localparam logic [1:0] OpSet    = 2'b00;
    localparam logic [1:0] OpClear  = 2'b01;
    localparam logic [1:0] OpToggle = 2'b10;
    localparam logic [1:0] OpPulse  = 2'b11;

    localparam logic [1:0] ModePushPull   = 2'b00;
    localparam logic [1:0] ModeOpenDrain  = 2'b01;
    localparam logic [1:0] ModeOpenSource = 2'b10;

    state_e              state_q, state_d;
    logic                level_q, level_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                done_d;
    logic                busy_d;
    logic                out_d, oe_d;
    logic                accept;

    assign cmd_ready_o = en_i & (state_q == IDLE);
    assign accept      = cmd_valid_i & cmd_ready_o;
    assign level_o     = level_q;

    // Next-state, level, pulse counter and completion strobe.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    unique case (cmd_op_i)
                        OpSet: begin
                            level_d = 1'b1;
                            done_d  = 1'b1;
                        end
                        OpClear: begin
                            level_d = 1'b0;
                            done_d  = 1'b1;
                        end
                        OpToggle: begin
                            level_d = ~level_q;
                            done_d  = 1'b1;
                        end
                        OpPulse: begin
                            // Counter holds remaining cycles minus one so a zero
                            // length behaves like a one-cycle pulse.
                            level_d = ~level_q;
                            cnt_d   = (cmd_len_i == '0) ? '0 : cmd_len_i - CntWidth'(1);
                            state_d = PULSE;
                        end
                        default: ;
                    endcase
                end
            end
            PULSE: begin
                if (!en_i) begin
                    // Abort: restore the pre-pulse level silently.
                    level_d = ~level_q;
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    level_d = ~level_q;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pad mapping from the next-state level so the pad moves on the same edge as level.
    always_comb begin
        out_d  = 1'b0;
        oe_d   = 1'b0;
        busy_d = (state_d == PULSE);
        if (en_i) begin
            unique case (mode_i)
                ModePushPull: begin
                    out_d = level_d;
                    oe_d  = 1'b1;
                end
                ModeOpenDrain: begin
                    out_d = 1'b0;
                    oe_d  = ~level_d;
                end
                ModeOpenSource: begin
                    out_d = 1'b1;
                    oe_d  = level_d;
                end
                default: begin
                    out_d = 1'b0;
                    oe_d  = 1'b0;
                end
            endcase
        end
    end

    // State, level, counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            level_q    <= ResetLevel;
            cnt_q      <= '0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            gpio_out_o <= 1'b0;
            gpio_oe_o  <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            done_o     <= done_d;
            busy_o     <= busy_d;
            gpio_out_o <= out_d;
            gpio_oe_o  <= oe_d;
        end
    end

endmodule

// File: tb/tb_gpio_output_stage.sv
// Purpose: self-checking bench for gpio_output_stage using an expected/observed scoreboard.
// Latency: one expected output vector per clock, compared against the sample taken 1ns after the edge.
// Backpressure: stimulus holds cmd_valid through busy periods to exercise ready gating.
module tb_gpio_output_stage;

    localparam int CW = 8;

    localparam logic [1:0] SET = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] TOG = 2'b10;
    localparam logic [1:0] PUL = 2'b11;

    // Observable bundle: {level, out, oe, busy, done, ready}
    typedef logic [5:0] vec_t;

    logic          clk;
    logic          rst_ni;
    logic          en_i;
    logic [1:0]    mode_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [CW-1:0] cmd_len_i;
    logic          gpio_out_o;
    logic          gpio_oe_o;
    logic          level_o;
    logic          busy_o;
    logic          done_o;

    int checks = 0;
    int errors = 0;

    vec_t exp_q[$];
    vec_t obs_q[$];

    gpio_output_stage #(
        .CntWidth  (CW),
        .ResetLevel(1'b0)
    ) dut (
        .clk        (clk),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i   (cmd_op_i),
        .cmd_len_i  (cmd_len_i),
        .gpio_out_o (gpio_out_o),
        .gpio_oe_o  (gpio_oe_o),
        .level_o    (level_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t observe();
        return {level_o, gpio_out_o, gpio_oe_o, busy_o, done_o, cmd_ready_o};
    endfunction

    // Drive one cycle of stimulus, record what the outputs must be after the edge,
    // then capture what the DUT actually shows.
    task automatic tick(input logic v, input logic [1:0] op, input logic [CW-1:0] len,
                        input logic e, input logic [1:0] m, input vec_t x);
        cmd_valid_i = v;
        cmd_op_i    = op;
        cmd_len_i   = len;
        en_i        = e;
        mode_i      = m;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        obs_q.push_back(observe());
    endtask

    task automatic test_reset();
        vec_t e, o;
        rst_ni = 1'b0;
        tick(1'b1, SET, '0, 1'b0, 2'b00, 6'b000000);
        tick(1'b1, SET, '0, 1'b0, 2'b00, 6'b000000);
        rst_ni = 1'b1;
        tick(1'b0, SET, '0, 1'b0, 2'b00, 6'b000000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_set_pushpull();
        vec_t e, o;
        tick(1'b1, SET, '0, 1'b1, 2'b00, 6'b111011);
        tick(1'b0, SET, '0, 1'b1, 2'b00, 6'b111001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL set_pushpull[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_open_drain_back_to_back();
        vec_t e, o;
        tick(1'b1, CLR, '0, 1'b1, 2'b01, 6'b001011);
        tick(1'b1, TOG, '0, 1'b1, 2'b01, 6'b100011);
        tick(1'b0, TOG, '0, 1'b1, 2'b01, 6'b100001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL open_drain_b2b[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_pulse_len5();
        vec_t e, o;
        tick(1'b1, CLR, '0, 1'b1, 2'b00, 6'b001011);
        tick(1'b0, CLR, '0, 1'b1, 2'b00, 6'b001001);
        tick(1'b1, PUL, CW'(5), 1'b1, 2'b00, 6'b111100);
        // A SET is held valid for the whole pulse; it must wait for IDLE.
        for (int k = 0; k < 4; k++) tick(1'b1, SET, '0, 1'b1, 2'b00, 6'b111100);
        tick(1'b1, SET, '0, 1'b1, 2'b00, 6'b001011);
        tick(1'b1, SET, '0, 1'b1, 2'b00, 6'b111011);
        tick(1'b0, SET, '0, 1'b1, 2'b00, 6'b111001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pulse_len5[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_pulse_short();
        vec_t e, o;
        for (int l = 0; l < 2; l++) begin
            tick(1'b1, PUL, CW'(l), 1'b1, 2'b00, 6'b001100);
            tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b111011);
            tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b111001);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pulse_short[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_pulse_max();
        vec_t e, o;
        int bad;
        bad = 0;
        tick(1'b1, PUL, {CW{1'b1}}, 1'b1, 2'b00, 6'b001100);
        for (int k = 0; k < (1 << CW) - 2; k++) tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b001100);
        tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b111011);
        tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b111001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                bad++;
                if (bad <= 4) $display("FAIL pulse_max[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_abort();
        vec_t e, o;
        tick(1'b1, PUL, CW'(10), 1'b1, 2'b00, 6'b001100);
        for (int k = 0; k < 3; k++) tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b001100);
        tick(1'b0, PUL, '0, 1'b0, 2'b00, 6'b100000);
        tick(1'b1, TOG, '0, 1'b0, 2'b00, 6'b100000);
        tick(1'b1, TOG, '0, 1'b0, 2'b00, 6'b100000);
        tick(1'b0, TOG, '0, 1'b1, 2'b00, 6'b111001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_modes();
        vec_t e, o;
        tick(1'b0, SET, '0, 1'b1, 2'b10, 6'b111001);
        tick(1'b0, SET, '0, 1'b1, 2'b11, 6'b100001);
        tick(1'b0, SET, '0, 1'b1, 2'b10, 6'b111001);
        tick(1'b0, SET, '0, 1'b1, 2'b01, 6'b100001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL modes[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        vec_t e, o;
        tick(1'b1, CLR, '0, 1'b1, 2'b00, 6'b001011);
        tick(1'b1, PUL, CW'(5), 1'b1, 2'b00, 6'b111100);
        tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b111100);
        // Reset lands between edges; outputs must clear without a clock.
        #2;
        rst_ni = 1'b0;
        #1;
        exp_q.push_back(6'b000001);
        obs_q.push_back(observe());
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        tick(1'b0, PUL, '0, 1'b1, 2'b00, 6'b001001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_mid_pulse[%0d]: got %b expected %b", i, o, e);
            end
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        en_i        = 1'b0;
        mode_i      = 2'b00;
        cmd_valid_i = 1'b0;
        cmd_op_i    = SET;
        cmd_len_i   = '0;
        test_reset();
        test_set_pushpull();
        test_open_drain_back_to_back();
        test_pulse_len5();
        test_pulse_short();
        test_pulse_max();
        test_abort();
        test_modes();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
